// File: rtl/regfile_dump_reader.sv
// Walks a NUM_REGS-entry register file two registers at a time and streams (address, data)
// beats over valid/ready. Optional macro DUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
`ifdef DUMP_CHECKSUM_EN
    output logic              out_last,
    output logic              out_is_cksum
`else
    output logic              out_last
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SEND_A = 3'd2,
        SEND_B = 3'd3,
`ifdef DUMP_CHECKSUM_EN
        SEND_CK = 3'd5,
`endif
        DONE   = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [PTR_W-1:0]  ptr_r, ptr_s;
    logic [DATA_W-1:0] hold_a_r, hold_a_s;
    logic [DATA_W-1:0] hold_b_r, hold_b_s;
    logic              last_pair_s;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_r, cksum_s;

    function automatic logic [DATA_W-1:0] cksum_fold(input logic [DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0] beat);
        return acc ^ beat;
    endfunction
`endif

    assign rd_addr1    = ptr_r[ADDR_W-1:0];
    assign rd_addr2    = ptr_r[ADDR_W-1:0] + ADDR_W'(1);
    assign last_pair_s = (ptr_r == LAST_PTR);

    // State, pointer and snapshot registers; clr dominates abort and everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            hold_a_r <= '0;
            hold_b_r <= '0;
`ifdef DUMP_CHECKSUM_EN
            cksum_r  <= '0;
`endif
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            hold_a_r <= hold_a_s;
            hold_b_r <= hold_b_s;
`ifdef DUMP_CHECKSUM_EN
            cksum_r  <= cksum_s;
`endif
        end
    end

    // Next-state, datapath updates and stream outputs decoded from registered state.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        hold_a_s  = hold_a_r;
        hold_b_s  = hold_b_r;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        out_last  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        cksum_s      = cksum_r;
        out_is_cksum = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    ptr_s   = '0;
                    state_s = FETCH;
`ifdef DUMP_CHECKSUM_EN
                    cksum_s = '0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (abort) begin
                    state_s = IDLE;
                    ptr_s   = '0;
                end else begin
                    hold_a_s = rd_data1;
                    hold_b_s = rd_data2;
                    state_s  = SEND_A;
                end
            end
            SEND_A: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = ptr_r[ADDR_W-1:0];
                out_data  = hold_a_r;
                if (abort) begin
                    state_s = IDLE;
                    ptr_s   = '0;
                end else if (out_ready) begin
                    state_s = SEND_B;
`ifdef DUMP_CHECKSUM_EN
                    cksum_s = cksum_fold(cksum_r, hold_a_r);
`endif
                end else begin
                    state_s = SEND_A;
                end
            end
            SEND_B: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = rd_addr2;
                out_data  = hold_b_r;
`ifdef DUMP_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = last_pair_s;
`endif
                if (abort) begin
                    state_s = IDLE;
                    ptr_s   = '0;
                end else if (out_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    cksum_s = cksum_fold(cksum_r, hold_b_r);
`endif
                    if (last_pair_s) begin
`ifdef DUMP_CHECKSUM_EN
                        state_s = SEND_CK;
`else
                        state_s = DONE;
`endif
                    end else begin
                        ptr_s   = ptr_r + PTR_W'(2);
                        state_s = FETCH;
                    end
                end else begin
                    state_s = SEND_B;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            SEND_CK: begin
                busy         = 1'b1;
                out_valid    = 1'b1;
                out_data     = cksum_r;
                out_last     = 1'b1;
                out_is_cksum = 1'b1;
                if (abort) begin
                    state_s = IDLE;
                    ptr_s   = '0;
                end else if (out_ready) begin
                    state_s = DONE;
                end else begin
                    state_s = SEND_CK;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                ptr_s   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a bench-side register file, an expected-beat queue
// built from the dump rules, and one negedge compare process.
module tb_regfile_dump_reader;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int LAT = CK ? 49 : 48;

    logic clk = 1'b0;
    logic clr = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic busy, done, out_valid, out_last, is_ck;
    logic [AW-1:0] rd_addr1, rd_addr2, out_addr;
    logic [DW-1:0] rd_data1, rd_data2, out_data;
    logic [DW-1:0] mem  [N];
    logic [DW-1:0] snap [N];
    logic [DW-1:0] seen [N];
    logic [DW-1:0] ck_seen;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
        logic          c;
    } beat_t;
    beat_t q[$];
    beat_t e;

    int vectors = 0, errs = 0, cyc = 0, done_cnt = 0, done_cyc = 0, start_edge = 0;
    logic st_prev = 1'b0, kill_prev = 1'b0, pl = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

    regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
`ifdef DUMP_CHECKSUM_EN
        .out_last(out_last), .out_is_cksum(is_ck)
`else
        .out_last(out_last)
`endif
    );
`ifndef DUMP_CHECKSUM_EN
    assign is_ck = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream: every register in address order, then the checksum beat if enabled.
    task automatic build_model();
        logic [DW-1:0] x;
        beat_t b;
        x = '0;
        q.delete();
        for (int i = 0; i < N; i++) begin
            b.a = AW'(i); b.d = snap[i]; b.l = (i == N - 1) && !CK; b.c = 1'b0;
            q.push_back(b);
            x = x ^ snap[i];
        end
        if (CK) begin
            b.a = '0; b.d = x; b.l = 1'b1; b.c = 1'b1;
            q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("extra_beat", 64'(out_addr), 64'hFFFF);
            end else begin
                e = q.pop_front();
                check("beat_addr", 64'(out_addr), 64'(e.a));
                check("beat_data", 64'(out_data), 64'(e.d));
                check("beat_last", 64'(out_last), 64'(e.l));
                check("beat_is_cksum", 64'(is_ck), 64'(e.c));
            end
            if (is_ck) ck_seen = out_data;
            else seen[out_addr] = out_data;
        end
        if (st_prev && !kill_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_addr", 64'(out_addr), 64'(pa));
            check("stall_data", 64'(out_data), 64'(pd));
            check("stall_last", 64'(out_last), 64'(pl));
        end
        st_prev   = out_valid && !out_ready;
        kill_prev = abort || clr;
        pa = out_addr; pd = out_data; pl = out_last;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_busy_low", 64'(busy), 64'd0);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1; start_edge = cyc + 1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_addr"}, 64'(out_addr), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_rd1"}, 64'(rd_addr1), 64'd0);
        check({tag, "_rd2"}, 64'(rd_addr2), 64'd1);
    endtask

    // mode 0: ready high; 1: ready 1,0,0 pattern; 2: ready high plus a stray start mid-dump.
    task automatic run_dump(input int mode);
        int d0;
        d0 = done_cnt;
        build_model();
        out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 600 && done_cnt == d0; k++) begin
            if (mode == 1) out_ready = (k % 3 == 0);
            start = (mode == 2) && (k == 20);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_once", 64'(done_cnt - d0), 64'd1);
        if (mode != 1) check("done_latency", 64'(done_cyc - start_edge), 64'(LAT));
        check("all_beats_seen", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int d0, phase;
        for (int i = 0; i < N; i++) mem[i] = 32'(i) * 32'h11111111;
        for (int i = 0; i < N; i++) snap[i] = mem[i];

        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); @(posedge clk); #1 clr = 1'b0;
        check_idle("reset");

        run_dump(0);
        check("pin_data15", 64'(seen[15]), 64'hFFFFFFFF);
        check("pin_data31", 64'(seen[31]), 64'h1111110F);

        run_dump(1);
        run_dump(2);

        // Snapshot: write lands before FETCH of pair 4/5, overwrite during its SEND_A.
        for (int i = 0; i < N; i++) snap[i] = mem[i];
        snap[5] = 32'hDEADBEEF;
        build_model();
        out_ready = 1'b1;
        d0 = done_cnt;
        phase = 0;
        pulse_start();
        for (int k = 0; k < 600 && done_cnt == d0; k++) begin
            if (phase == 0 && out_valid && out_addr == 5'd3) begin
                @(posedge clk); #1 mem[5] = 32'hDEADBEEF; phase = 1;
            end else if (phase == 1 && out_valid && out_addr == 5'd4) begin
                mem[5] = 32'h00000000; phase = 2;
            end
            @(posedge clk); #1;
        end
        check("snap_done", 64'(done_cnt - d0), 64'd1);
        check("snap_beat5", 64'(seen[5]), 64'hDEADBEEF);
        check("snap_drained", 64'(q.size()), 64'd0);
        mem[5] = 32'h55555555;
        for (int i = 0; i < N; i++) snap[i] = mem[i];

        // Abort while beat 10 is stalled.
        build_model();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        for (int k = 0; k < 200; k++) begin
            if (out_valid && out_addr == 5'd10) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("abort_reached_10", 64'(out_addr), 64'd10);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rd1", 64'(rd_addr1), 64'd0);
        q.delete();
        repeat (60) @(posedge clk);
        #1 check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_dump(0);

        // clr during SEND_B of pair 20/21.
        build_model();
        out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 200; k++) begin
            if (out_valid && out_addr == 5'd21) break;
            @(posedge clk); #1;
        end
        check("clr_reached_21", 64'(out_addr), 64'd21);
        out_ready = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        check_idle("clr_mid");
        q.delete();
        out_ready = 1'b1;

`ifdef DUMP_CHECKSUM_EN
        for (int i = 0; i < N; i++) mem[i] = '0;
        mem[1] = 32'hF0F0F0F0;
        mem[2] = 32'h0F0F0F0F;
        for (int i = 0; i < N; i++) snap[i] = mem[i];
        run_dump(0);
        check("cksum_value", 64'(ck_seen), 64'hFFFFFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
